// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: register map, FSM encoding, divider width and reset default.
package spi_pkg;

  localparam int DIV_W = 8;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIV  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  // Bit positions inside the control/status register.
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_SS     = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam logic [DIV_W-1:0] DIV_RESET_DEF = 8'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period prescaler: while running, counts 0..div and pulses tick_o on the last count.
module spi_sck_gen
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == div_i);

  // Counter rests at zero while idle so the first half-period after a start is full length.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, with a four-register bus interface.
// Define SPI_IRQ_EN to add the irq output and the irq_en control bit.
module spi_master
  import spi_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             ss_n
`ifdef SPI_IRQ_EN
  ,
  output logic             irq
`endif
);

  state_t           state_q, state_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       rx_q, rx_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic             ss_q, ss_d;
  logic             irq_en_q;
  logic             busy;
  logic             tick;

  assign busy = (state_q != IDLE);

  spi_sck_gen u_sck_gen (
    .clk    (clk),
    .reset  (reset),
    .run_i  (busy),
    .div_i  (div_lat_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    rx_d      = rx_q;
    done_d    = done_q;
    div_d     = div_q;
    div_lat_d = div_lat_q;
    ss_d      = ss_q;

    // Read-to-clear comes first so a completion in the same cycle overrides it.
    if (re && addr == ADDR_DATA) done_d = 1'b0;
    if (we && addr == ADDR_DIV)  div_d  = wdata;
    if (we && addr == ADDR_CTRL) ss_d   = wdata[CTRL_SS];

    unique case (state_q)
      IDLE: begin
        if (we && addr == ADDR_DATA) begin
          state_d   = LOW;
          div_lat_d = div_q;
          shift_d   = wdata;
          mosi_d    = wdata[7];
          bit_d     = '0;
          done_d    = 1'b0;
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], miso};
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rx_d    = shift_q;
          end else begin
            state_d = LOW;
            mosi_d  = shift_q[7];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      shift_q   <= '0;
      bit_q     <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= DIV_RESET;
      div_lat_q <= DIV_RESET;
      ss_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      ss_q      <= ss_d;
    end
  end

`ifdef SPI_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (we && addr == ADDR_CTRL) irq_en_q <= wdata[CTRL_IRQ_EN];
      irq_q <= done_q & irq_en_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA: rdata = rx_q;
      ADDR_DIV:  rdata = div_q;
      ADDR_CTRL: begin
        rdata[CTRL_BUSY]   = busy;
        rdata[CTRL_SS]     = ss_q;
        rdata[CTRL_DONE]   = done_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default:   rdata = '0;
    endcase
  end

  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign ss_n = ~ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master; expectations come from the transfer rules
// (bit order, 16*(DIV+1) busy length, 2*(DIV+1) sck period), not from the RTL structure.
module tb_spi_master;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_DIV  = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_RSVD = 2'd3;

  logic       clk;
  logic       reset;
  logic       we;
  logic       re;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ss_n;
`ifdef SPI_IRQ_EN
  logic       irq;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference register state
  logic [7:0] m_div;

  spi_master #(.DIV_RESET(8'd7)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (miso),
    .ss_n  (ss_n)
`ifdef SPI_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    #1 d = rdata;
    step();
    re = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  // One full transfer; optionally a bus write (ia/id) is injected 4 clk after the start.
  task automatic xfer(input string tag, input bit wdiv, input logic [7:0] div_w,
                      input logic [7:0] tx, input logic [7:0] mb, input bit loop,
                      input bit intr, input logic [1:0] ia, input logic [7:0] id);
    int n_busy, n_rise, last_rise, bad_per, cyc;
    logic [7:0] seq, cur, exp_rx, r;
    logic prev_sck, finished;
    if (wdiv) begin
      wr(A_DIV, div_w);
      m_div = div_w;
    end
    cur    = m_div;
    exp_rx = loop ? tx : mb;
    miso   = loop ? tx[7] : mb[7];
    wr(A_DATA, tx);
    addr = A_CTRL;
    #1;
    n_busy = 0; n_rise = 0; last_rise = 0; bad_per = 0; seq = '0;
    prev_sck = 1'b0; finished = 1'b0;
    for (cyc = 0; cyc < 8000; cyc++) begin
      if (addr == A_CTRL && !rdata[0]) begin
        finished = 1'b1;
        break;
      end
      n_busy++;
      if (sck && !prev_sck) begin
        seq = {seq[6:0], mosi};
        if (n_rise > 0 && (cyc - last_rise) != 2 * (int'(cur) + 1)) bad_per++;
        last_rise = cyc;
        n_rise++;
        if (!loop && n_rise < 8) miso = mb[7 - n_rise];
      end
      prev_sck = sck;
      if (loop) miso = mosi;
      if (intr && cyc == 3) begin
        we = 1'b1; addr = ia; wdata = id;
      end else begin
        we = 1'b0; addr = A_CTRL;
      end
      step();
    end
    we = 1'b0;
    if (!finished) chk({tag, ".timeout"}, 32'd0, 32'd1);
    chk({tag, ".busy_len"}, n_busy, 16 * (int'(cur) + 1));
    chk({tag, ".pulses"}, n_rise, 8);
    chk({tag, ".period_err"}, bad_per, 0);
    chk({tag, ".mosi"}, seq, tx);
    chk({tag, ".sck_idle"}, sck, 1'b0);
    if (intr && ia == A_DIV) m_div = id;
    peek(A_CTRL, r);
    chk({tag, ".done"}, r[2], 1'b1);
    rd(A_DATA, r);
    chk({tag, ".rx"}, r, exp_rx);
    peek(A_CTRL, r);
    chk({tag, ".done_clr"}, r[2], 1'b0);
    peek(A_DIV, r);
    chk({tag, ".div"}, r, m_div);
    step();
  endtask

  // Read of addr 0 lands on the same edge that completes the transfer.
  task automatic done_race(input logic [7:0] d);
    logic [7:0] r;
    wr(A_DIV, d);
    m_div = d;
    wr(A_DATA, 8'($urandom));
    repeat (16 * (int'(d) + 1) - 1) step();
    addr = A_DATA; re = 1'b1;
    step();
    re = 1'b0;
    peek(A_CTRL, r);
    chk("race.busy", r[0], 1'b0);
    chk("race.done_kept", r[2], 1'b1);
    rd(A_DATA, r);
    peek(A_CTRL, r);
    chk("race.done_clr", r[2], 1'b0);
    step();
  endtask

  initial begin
    logic [7:0] r;
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = A_DATA; wdata = '0; miso = 1'b0;
    m_div = 8'd7;
    repeat (3) step();
    reset = 1'b0;

    chk("rst.sck", sck, 1'b0);
    chk("rst.mosi", mosi, 1'b0);
    chk("rst.ss_n", ss_n, 1'b1);
    peek(A_DATA, r); chk("rst.rx", r, 8'h00);
    peek(A_DIV, r);  chk("rst.div", r, 8'h07);
    peek(A_CTRL, r); chk("rst.ctrl", r, 8'h00);
    step();

    // Reserved address and control-register field behaviour
    wr(A_RSVD, 8'hFF);
    peek(A_RSVD, r); chk("rsvd.read", r, 8'h00);
    peek(A_DIV, r);  chk("rsvd.div_untouched", r, 8'h07);
    step();
    wr(A_CTRL, 8'hFF);
    peek(A_CTRL, r);
`ifdef SPI_IRQ_EN
    chk("ctrl.fields", r, 8'h0A);
`else
    chk("ctrl.fields", r, 8'h02);
`endif
    chk("ctrl.ss_n", ss_n, 1'b0);
    step();
    wr(A_CTRL, 8'h00);
    chk("ctrl.ss_n_off", ss_n, 1'b1);

    xfer("div0", 1'b1, 8'd0, 8'hA5, 8'h3C, 1'b0, 1'b0, A_DATA, 8'h00);
    xfer("div3", 1'b1, 8'd3, 8'hFF, 8'($urandom), 1'b0, 1'b0, A_DATA, 8'h00);
    xfer("double", 1'b1, 8'd1, 8'h11, 8'($urandom), 1'b0, 1'b1, A_DATA, 8'h22);
    xfer("loop5a", 1'b1, 8'd2, 8'h5A, 8'h00, 1'b1, 1'b0, A_DATA, 8'h00);
    xfer("divwr", 1'b1, 8'd2, 8'($urandom), 8'($urandom), 1'b0, 1'b1, A_DIV, 8'd0);
    xfer("divnext", 1'b0, 8'd0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, A_DATA, 8'h00);

    for (int i = 0; i < 6; i++) begin
      xfer($sformatf("rnd%0d", i), 1'b1, 8'($urandom_range(0, 4)), 8'($urandom),
           8'($urandom), 1'($urandom_range(0, 1)), 1'b0, A_DATA, 8'h00);
    end

    done_race(8'd0);
    done_race(8'd2);

    // Asynchronous reset in the middle of a DIV=1 transfer
    wr(A_CTRL, 8'h02);
    chk("mid.ss_on", ss_n, 1'b0);
    wr(A_DIV, 8'd1);
    wr(A_DATA, 8'hC3);
    repeat (9) step();
    peek(A_CTRL, r); chk("mid.busy_before", r[0], 1'b1);
    reset = 1'b1;
    #1;
    chk("mid.sck", sck, 1'b0);
    chk("mid.ss_n", ss_n, 1'b1);
    chk("mid.mosi", mosi, 1'b0);
    peek(A_CTRL, r); chk("mid.ctrl", r, 8'h00);
    peek(A_DIV, r);  chk("mid.div", r, 8'h07);
    peek(A_DATA, r); chk("mid.rx", r, 8'h00);
    reset = 1'b0;
    m_div = 8'd7;
    step();
    xfer("post_rst", 1'b0, 8'd0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, A_DATA, 8'h00);

`ifdef SPI_IRQ_EN
    begin
      logic seen;
      wr(A_CTRL, 8'h08);
      wr(A_DIV, 8'd0);
      m_div = 8'd0;
      wr(A_DATA, 8'h96);
      repeat (15) step();
      chk("irq.busy", irq, 1'b0);
      step();
      peek(A_CTRL, r); chk("irq.done", r[2], 1'b1);
      chk("irq.same_clk", irq, 1'b0);
      step();
      chk("irq.rise", irq, 1'b1);
      rd(A_DATA, r);
      chk("irq.hold", irq, 1'b1);
      step();
      chk("irq.drop", irq, 1'b0);
      wr(A_CTRL, 8'h00);
      wr(A_DATA, 8'h3C);
      seen = 1'b0;
      repeat (24) begin
        seen = seen | irq;
        step();
      end
      chk("irq.disabled", seen, 1'b0);
      rd(A_DATA, r);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
